// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: operation and format enums, opcode
// constants, immediate field widths and the immediate range helper.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_ANDREG = 4'd0,
        OP_ORRREG = 4'd1,
        OP_ADDREG = 4'd2,
        OP_SUBREG = 4'd3,
        OP_ADDIMM = 4'd4,
        OP_SUBIMM = 4'd5,
        OP_MOVZ   = 4'd6,
        OP_B      = 4'd7,
        OP_CBZ    = 4'd8,
        OP_LDUR   = 4'd9,
        OP_STUR   = 4'd10
    } op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_D, FMT_B, FMT_CB, FMT_IW, FMT_BAD
    } fmt_e;

    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

    localparam int IMM12_W = 12;
    localparam int IMM9_W  = 9;
    localparam int IMM16_W = 16;
    localparam int IMM26_W = 26;
    localparam int IMM19_W = 19;

    typedef struct packed {
        logic [31:0] word;
        logic        legal;
        logic        in_range;
    } pack_t;

    function automatic fmt_e op_fmt(input logic [3:0] op);
        case (op)
            OP_ANDREG, OP_ORRREG, OP_ADDREG, OP_SUBREG: return FMT_R;
            OP_ADDIMM, OP_SUBIMM:                       return FMT_I;
            OP_LDUR, OP_STUR:                           return FMT_D;
            OP_B:                                       return FMT_B;
            OP_CBZ:                                     return FMT_CB;
            OP_MOVZ:                                    return FMT_IW;
            default:                                    return FMT_BAD;
        endcase
    endfunction

    // Bits above the field must be zero, or for signed fields a copy of the field's sign bit.
    function automatic logic imm_fits(input logic [25:0] imm, input int unsigned w,
                                      input logic is_signed);
        logic [25:0] hi_mask;
        logic [25:0] top_bit;
        logic [25:0] hi;
        hi_mask = ~((26'd1 << w) - 26'd1);
        top_bit = 26'd1 << (w - 1);
        hi      = imm & hi_mask;
        return (hi == 26'd0) || (is_signed && (hi == hi_mask) && |(imm & top_bit));
    endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// Combinational LEGv8 field packer: op + register/immediate fields into a
// 32-bit word, with legality and immediate range flags.
module instr_field_pack
    import legv8_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rn,
    input  logic [4:0]  i_rm,
    input  logic [25:0] i_imm,
    input  logic [1:0]  i_hw,
    output pack_t       o_pack
);

    fmt_e        w_fmt;
    logic [10:0] w_ropc;

    assign w_fmt = op_fmt(i_op);

    always_comb begin
        case (i_op[1:0])
            2'd0:    w_ropc = OPC_AND;
            2'd1:    w_ropc = OPC_ORR;
            2'd2:    w_ropc = OPC_ADD;
            default: w_ropc = OPC_SUB;
        endcase
    end

    // Encoding is always truncating; the range flag is consumed only when checking is built in.
    always_comb begin
        o_pack.word     = 32'd0;
        o_pack.legal    = 1'b1;
        o_pack.in_range = 1'b1;
        case (w_fmt)
            FMT_R:  o_pack.word = {w_ropc, i_rm, 6'd0, i_rn, i_rd};
            FMT_I: begin
                o_pack.word     = {(i_op[0] ? OPC_SUBI : OPC_ADDI), i_imm[IMM12_W-1:0], i_rn, i_rd};
                o_pack.in_range = imm_fits(i_imm, IMM12_W, 1'b0);
            end
            FMT_D: begin
                o_pack.word     = {(i_op[0] ? OPC_LDUR : OPC_STUR), i_imm[IMM9_W-1:0], 2'b00, i_rn, i_rd};
                o_pack.in_range = imm_fits(i_imm, IMM9_W, 1'b1);
            end
            FMT_B:  o_pack.word = {OPC_B, i_imm[IMM26_W-1:0]};
            FMT_CB: begin
                o_pack.word     = {OPC_CBZ, i_imm[IMM19_W-1:0], i_rd};
                o_pack.in_range = imm_fits(i_imm, IMM19_W, 1'b1);
            end
            FMT_IW: begin
                o_pack.word     = {OPC_MOVZ, i_hw, i_imm[IMM16_W-1:0], i_rd};
                o_pack.in_range = imm_fits(i_imm, IMM16_W, 1'b0);
            end
            default: o_pack.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder / instruction-memory loader: one accepted
// instruction becomes one registered imem write. Define
// INSTR_ENC_RANGE_CHECK_EN to reject immediates that do not fit their field.
module instr_encoder
    import legv8_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic             start,
    input  logic [63:0]      start_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rn,
    input  logic [4:0]       rm,
    input  logic [25:0]      imm,
    input  logic [1:0]       hw,
    input  logic             last,
    output logic             imem_we,
    output logic [63:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [CNT_W:0]   count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]     r_state;
    logic [63:0]    r_base;
    logic [63:0]    r_addr;
    logic [31:0]    r_wdata;
    logic           r_last;
    logic [CNT_W:0] r_count;
    logic           r_err;

    pack_t          w_pack;
    logic           w_accept;
    logic           w_range_ok;
    logic           w_full;

    instr_field_pack u_pack (
        .i_op   (op),
        .i_rd   (rd),
        .i_rn   (rn),
        .i_rm   (rm),
        .i_imm  (imm),
        .i_hw   (hw),
        .o_pack (w_pack)
    );

`ifdef INSTR_ENC_RANGE_CHECK_EN
    assign w_range_ok = w_pack.in_range;
`else
    logic w_unused_range;
    assign w_unused_range = w_pack.in_range;
    assign w_range_ok     = 1'b1;
`endif

    // count never exceeds DEPTH, so its MSB alone marks a full memory.
    assign w_full   = r_count[CNT_W];
    assign in_ready = (r_state == S_ACCEPT) && !start;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state <= S_IDLE;
            r_base  <= 64'd0;
            r_addr  <= 64'd0;
            r_wdata <= 32'd0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (start) begin
            // A new session from any state; a write in flight is abandoned.
            r_state <= S_ACCEPT;
            r_base  <= start_addr;
            r_last  <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_ACCEPT: begin
                    if (w_accept) begin
                        if (w_full) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (!w_pack.legal || !w_range_ok) begin
                            r_err <= 1'b1;
                            if (last) r_state <= S_DONE;
                        end else begin
                            r_wdata <= w_pack.word;
                            r_addr  <= r_base + 64'({r_count, 2'b00});
                            r_last  <= last;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + (CNT_W+1)'(1);
                    r_state <= r_last ? S_DONE : S_ACCEPT;
                end
                default: ;
            endcase
        end
    end

    // Strobe decodes straight from state so an async reset kills it at once.
    assign imem_we    = (r_state == S_WRITE) && !start;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign busy       = (r_state == S_ACCEPT) || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed checks from the worked
// examples plus randomized sessions against a transaction-level model.
module tb_instr_encoder;

    localparam int CNT_W = 2;
    localparam int DEPTH = 1 << CNT_W;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             resetl = 1'b1;
    logic             start = 1'b0;
    logic [63:0]      start_addr = 64'd0;
    logic             in_valid = 1'b0;
    logic [3:0]       op = 4'd0;
    logic [4:0]       rd = 5'd0, rn = 5'd0, rm = 5'd0;
    logic [25:0]      imm = 26'd0;
    logic [1:0]       hw = 2'd0;
    logic             last = 1'b0;
    logic             in_ready, imem_we, busy, done, err;
    logic [63:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic [CNT_W:0]   count;

    int n_chk  = 0;
    int n_fail = 0;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .resetl(resetl), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rn(rn),
        .rm(rm), .imm(imm), .hw(hw), .last(last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          legal;
        bit          inr;
        logic [31:0] word;
    } enc_t;

    // Encoding by place-value arithmetic on the field layout.
    function automatic enc_t enc(input int o, input int d, input int n, input int m,
                                 input longint i, input int h);
        enc_t   r;
        longint opc;
        longint w;
        r.legal = 1'b1;
        r.inr   = 1'b1;
        w       = 0;
        opc     = 0;
        case (o)
            0, 1, 2, 3: begin
                opc = (o == 0) ? 'h450 : (o == 1) ? 'h550 : (o == 2) ? 'h458 : 'h658;
                w   = opc * 2097152 + m * 65536 + n * 32 + d;
            end
            4, 5: begin
                opc   = (o == 4) ? 'h244 : 'h344;
                w     = opc * 4194304 + (i % 4096) * 1024 + n * 32 + d;
                r.inr = (i < 4096);
            end
            6: begin
                opc   = 'h1A5;
                w     = opc * 8388608 + h * 2097152 + (i % 65536) * 32 + d;
                r.inr = (i < 65536);
            end
            7: begin
                opc = 5;
                w   = opc * 67108864 + i;
            end
            8: begin
                opc   = 'hB4;
                w     = opc * 16777216 + (i % 524288) * 32 + d;
                r.inr = (i < 262144) || (i >= 67108864 - 262144);
            end
            9, 10: begin
                opc   = (o == 9) ? 'h7C2 : 'h7C0;
                w     = opc * 2097152 + (i % 512) * 4096 + n * 32 + d;
                r.inr = (i < 256) || (i >= 67108864 - 256);
            end
            default: r.legal = 1'b0;
        endcase
        r.word = w[31:0];
        return r;
    endfunction

    typedef struct {
        logic [63:0] addr;
        logic [31:0] word;
        bit          last;
    } wr_t;

    bit          m_act = 0, m_fin = 0, m_err = 0;
    int          m_cnt = 0;
    logic [63:0] m_base = 64'd0;
    wr_t         m_q[$];

    // Compare outputs against the model, then advance the model with the
    // inputs the coming rising edge will sample.
    always @(negedge CLK) begin : cmp
        enc_t e;
        wr_t  w;
        bit   exp_we, exp_rdy;
        if (!resetl) begin
            m_act = 0; m_fin = 0; m_err = 0; m_cnt = 0;
            m_q.delete();
            chk("rst_ready", in_ready, 0);
            chk("rst_we", imem_we, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_wdata", imem_wdata, 0);
            chk("rst_count", count, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
        end else begin
            exp_we  = (m_q.size() != 0) && !start;
            exp_rdy = m_act && !m_fin && (m_q.size() == 0) && !start;
            chk("m_we", imem_we, exp_we);
            chk("m_ready", in_ready, exp_rdy);
            chk("m_count", count, m_cnt);
            chk("m_busy", busy, m_act);
            chk("m_done", done, m_fin);
            chk("m_err", err, m_err);
            if (exp_we) begin
                chk("m_addr", imem_addr, m_q[0].addr);
                chk("m_wdata", imem_wdata, m_q[0].word);
            end
            if (start) begin
                m_act = 1; m_fin = 0; m_err = 0; m_cnt = 0;
                m_base = start_addr;
                m_q.delete();
            end else if (m_q.size() != 0) begin
                w = m_q.pop_front();
                m_cnt++;
                if (w.last) begin m_fin = 1; m_act = 0; end
            end else if (exp_rdy && in_valid) begin
                e = enc(int'(op), int'(rd), int'(rn), int'(rm), longint'(imm), int'(hw));
                if (m_cnt == DEPTH) begin
                    m_err = 1; m_fin = 1; m_act = 0;
                end else if (!e.legal || (RC_EN && !e.inr)) begin
                    m_err = 1;
                    if (last) begin m_fin = 1; m_act = 0; end
                end else begin
                    w.addr = m_base + 64'(m_cnt * 4);
                    w.word = e.word;
                    w.last = last;
                    m_q.push_back(w);
                end
            end
        end
    end

    // All driver tasks start and end at 1 time unit after a rising edge.
    task automatic do_start(input logic [63:0] a);
        start = 1'b1;
        start_addr = a;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic send(input int o, input int d, input int n, input int m,
                        input logic [25:0] i, input int h, input bit l);
        bit ok;
        ok = 0;
        op = 4'(o); rd = 5'(d); rn = 5'(n); rm = 5'(m); imm = i; hw = 2'(h); last = l;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("ready_timeout", 0, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        last = 1'b0;
    endtask

    function automatic logic [25:0] rnd_imm();
        int unsigned s;
        s = $urandom_range(0, 2);
        if (s == 0) return 26'($urandom_range(0, 300));
        if (s == 1) return 26'(67108864 - $urandom_range(1, 300));
        return 26'($urandom);
    endfunction

    initial begin
        enc_t e;
        #2 resetl = 1'b0;
        repeat (3) @(posedge CLK);
        #1 resetl = 1'b1;

        e = enc(2, 3, 1, 2, 0, 0);          chk("mdl_addreg", e.word, 32'h8B020023);
        e = enc(9, 5, 4, 0, 8, 0);          chk("mdl_ldur", e.word, 32'hF8408085);
        e = enc(6, 9, 0, 0, 'h1234, 1);     chk("mdl_movz", e.word, 32'hD2A24689);
        e = enc(7, 0, 0, 0, 'h3FFFFFF, 0);  chk("mdl_b", e.word, 32'h17FFFFFF);
        e = enc(8, 7, 0, 0, 2, 0);          chk("mdl_cbz", e.word, 32'hB4000047);

        @(posedge CLK); #1;
        chk("idle_ready", in_ready, 0);

        do_start(64'h100);
        send(2, 3, 1, 2, 26'd0, 0, 0);
        chk("add_we", imem_we, 1);
        chk("add_addr", imem_addr, 64'h100);
        chk("add_wdata", imem_wdata, 32'h8B020023);
        @(posedge CLK); #1;
        chk("add_count", count, 1);
        send(9, 5, 4, 0, 26'd8, 0, 0);
        chk("ldur_addr", imem_addr, 64'h104);
        chk("ldur_wdata", imem_wdata, 32'hF8408085);
        send(6, 9, 0, 0, 26'h1234, 1, 0);
        chk("movz_addr", imem_addr, 64'h108);
        chk("movz_wdata", imem_wdata, 32'hD2A24689);
        send(7, 0, 0, 0, 26'h3FFFFFF, 0, 1);
        chk("b_addr", imem_addr, 64'h10C);
        chk("b_wdata", imem_wdata, 32'h17FFFFFF);
        @(posedge CLK); #1;
        chk("sess_done", done, 1);
        chk("sess_count", count, 4);
        chk("sess_busy", busy, 0);

        do_start(64'h200);
        send(8, 7, 0, 0, 26'd2, 0, 0);
        chk("cbz_wdata", imem_wdata, 32'hB4000047);
        send(12, 1, 1, 1, 26'd0, 0, 0);
        chk("illegal_we", imem_we, 0);
        chk("illegal_err", err, 1);
        chk("illegal_count", count, 1);

        do_start(64'h300);
        send(4, 1, 2, 0, 26'h1000, 0, 0);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        chk("range_we", imem_we, 0);
        chk("range_err", err, 1);
`else
        chk("trunc_we", imem_we, 1);
        chk("trunc_wdata", imem_wdata, 32'h91000041);
`endif

        do_start(64'h0);
        for (int k = 0; k < DEPTH; k++) send(0, 1, 2, 3, 26'd0, 0, 0);
        send(1, 1, 2, 3, 26'd0, 0, 0);
        chk("cap_err", err, 1);
        chk("cap_done", done, 1);
        chk("cap_we", imem_we, 0);
        chk("cap_count", count, DEPTH);

        do_start(64'h40);
        send(3, 4, 5, 6, 26'd0, 0, 0);
        chk("mid_we_before", imem_we, 1);
        #1 resetl = 1'b0;
        #1;
        chk("mid_we_after", imem_we, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", in_ready, 0);
        @(posedge CLK); #1 resetl = 1'b1;

        for (int k = 0; k < 400; k++) begin
            @(posedge CLK); #1;
            if (!m_act || m_fin || $urandom_range(0, 24) == 0) begin
                do_start({$urandom, $urandom} & ~64'h3);
            end else begin
                send($urandom_range(0, 12), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), rnd_imm(), $urandom_range(0, 3),
                     $urandom_range(0, 7) == 0);
                if ($urandom_range(0, 11) == 0) do_start({$urandom, $urandom} & ~64'h3);
            end
        end

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential LEGv8 instruction encoder and instruction-memory loader. Accepts one symbolic instruction per handshake (operation select plus register/immediate fields), packs it into the 32-bit R/I/D/B/CB/IW word format understood by the processor's control decoder, and writes it to consecutive instruction-memory word addresses. It sits between the testbench/boot sequencer and instruction memory, ahead of the single-cycle datapath.

## Interface
Parameters:
- CNT_W, 8, width of the instruction counter; capacity DEPTH = 2**CNT_W words

Ports:
- CLK  in  1  clock, rising edge
- resetl  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session
- start_addr  in  64  byte base address, latched on start
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept
- op  in  4  0 ANDREG, 1 ORRREG, 2 ADDREG, 3 SUBREG, 4 ADDIMM, 5 SUBIMM, 6 MOVZ, 7 B, 8 CBZ, 9 LDUR, 10 STUR; 11–15 illegal
- rd  in  5  Rd/Rt
- rn  in  5  Rn
- rm  in  5  Rm
- imm  in  26  immediate: imm12, imm9, imm16, imm26 or imm19, right-justified
- hw  in  2  MOVZ shift select
- last  in  1  marks final instruction of session
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  64  byte address
- imem_wdata  out  32  encoded word
- count  out  CNT_W+1  words written this session
- busy  out  1  session active
- done  out  1  session complete (sticky)
- err  out  1  error seen (sticky)

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0. start → ACCEPT; latch start_addr; clear count, done and err.
- ACCEPT: in_ready=1 except in a cycle where start=1. On in_valid&&in_ready, the encoded word, address and last flag are registered, then → WRITE.
- WRITE: imem_we=1 for exactly one cycle, imem_addr = base + {count,2'b00}; count increments. Next state is DONE if last, else ACCEPT.
- DONE: done=1, busy=0. start → ACCEPT (new session).
- Field packing, shamt=0:
  - R: opcode 10001010000 (AND), 10101010000 (ORR), 10001011000 (ADD), 11001011000 (SUB); Rm, shamt, Rn, Rd.
  - I: 1001000100 (ADDI) / 1101000100 (SUBI); imm12 in [21:10].
  - D: 11111000010 (LDUR) / 11111000000 (STUR); imm9 in [20:12]; [11:10]=00.
  - B: 000101; imm26.
  - CB: 10110100; imm19 in [23:5]; Rt.
  - IW: 110100101; hw in [22:21]; imm16 in [20:5].
- Illegal op: err=1; no write; count unchanged; stays in ACCEPT, or goes to DONE if last.
- Capacity: an accept when count==DEPTH sets err=1, drops the word and → DONE.
- start in any non-IDLE state aborts the session: any pending write is dropped and the state → ACCEPT with cleared counters.
- Reset: state=IDLE; every output 0, including imem_addr, imem_wdata and count.

## Timing
- Accept at edge N: imem_we high during cycle N+1; in_ready returns high at N+2. Peak throughput is one word per 2 cycles.
- imem_wdata and imem_addr are registered and stable for the whole imem_we cycle.
- done rises the cycle after the last write.
- Asynchronous reset during WRITE suppresses the strobe immediately.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined:
  - imm bits above the field width must be zero. Exception: signed fields (imm9, imm19, imm26) may instead be a correct sign extension.
  - Any other value sets err, drops the word and does not increment count.
- Undefined: imm is silently truncated to the field width; err is never set for range.

## Structure
- Package legv8_pkg: op enum, 11-bit opcode constants, field widths (12/9/16/26/19), format enum.
- Sub-module instr_field_pack: combinational op+fields → {word, legal, in_range}; instr_encoder holds the FSM, registers and counter.

## Test plan
- start, start_addr=0x100; ADDREG rd=3 rn=1 rm=2 last=0 → imem_we at addr 0x100, wdata 0x8B020023, count=1.
- LDUR rd=5 rn=4 imm=8 → addr 0x104, wdata 0xF8408085.
- MOVZ rd=9 imm=0x1234 hw=1, then B imm=0x3FFFFFF last=1 → 0xD2A24689, 0x17FFFFFF; done=1, count=4.
- CBZ rd=7 imm=2 → 0xB4000047; op=12 → err=1, no strobe, count unchanged.
- With INSTR_ENC_RANGE_CHECK_EN: ADDIMM imm=0x1000 → err=1, no write. Without the macro: wdata imm field 0x000.
- CNT_W=2: 5th accept → err=1, DONE; resetl low mid-WRITE → imem_we=0 immediately, state IDLE.
